// File: rtl/scratch_pad_bank.sv
// Purpose : per-FPGA ID/debug register bank on the OPB slave decode.
// Latency : every SP_RE/SP_WE strobe is acknowledged exactly one cycle later.
// Backpressure: none; the bank accepts one access per cycle, back to back.
//
// Register map (word address, OPB_ADDR[4:0]):
//    0 VERSION (RO)   1 ID (RO)   2 DATE (RO)   3 UPTIME (RO)
//    4 KEY (W: unlock key sequence, R: {30'b0, lock_state})
//    8 .. 8+NUM_SP-1  scratch registers, writable only while UNLOCKED
//
// Ports:
//    OPB_CLK    clock
//    OPB_RST    synchronous active-high reset
//    OPB_ADDR   word address, only [4:0] decoded
//    SP_DI      write data
//    SP_BE      byte enables, SP_BE[n] gates SP_DI[8n+7:8n] (scratch only)
//    SP_RE      read strobe, one cycle per access
//    SP_WE      write strobe, one cycle per access
//    SP_DO      read data, zero whenever SP_ACK is low
//    SP_ACK     one-cycle acknowledge
//    SP_ERR     qualifies SP_ACK, 1 = access rejected
//    SP_LOCKED  1 whenever the lock FSM is not UNLOCKED

module scratch_pad_bank #(
   parameter logic [31:0] VERSION        = 32'h1234_5678,
   parameter logic [31:0] ID             = 32'h0000_0050,
   parameter logic [31:0] DATE           = 32'h2025_0714,
   parameter int          NUM_SP         = 4,              // legal 1..8
   parameter logic [31:0] SP_INIT        = 32'hCAFE_0000,
   parameter int          UNLOCK_TIMEOUT = 1024             // 0 = never relock
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST,
   input  logic [31:0] OPB_ADDR,
   input  logic [31:0] SP_DI,
   input  logic [3:0]  SP_BE,
   input  logic        SP_RE,
   input  logic        SP_WE,
   output logic [31:0] SP_DO,
   output logic        SP_ACK,
   output logic        SP_ERR,
   output logic        SP_LOCKED
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [31:0] KEY_ARM    = 32'h0000_A5A5;
   localparam logic [31:0] KEY_UNLOCK = 32'h0000_5A5A;

   localparam logic [4:0] ADDR_VERSION = 5'd0;
   localparam logic [4:0] ADDR_ID      = 5'd1;
   localparam logic [4:0] ADDR_DATE    = 5'd2;
   localparam logic [4:0] ADDR_UPTIME  = 5'd3;
   localparam logic [4:0] ADDR_KEY     = 5'd4;

   localparam logic [3:0] NUM_SP_W = 4'(NUM_SP);

   // Idle counter only has to reach UNLOCK_TIMEOUT-1; relock happens on the
   // edge that would take it to UNLOCK_TIMEOUT.
   localparam int IDLE_W  = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
   localparam int TO_M1   = (UNLOCK_TIMEOUT > 0) ? UNLOCK_TIMEOUT - 1 : 0;
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TO_M1);
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      ARMED    = 2'd1,
      UNLOCKED = 2'd2
   } lock_state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   lock_state_t        lock_state;
   lock_state_t        lock_nxt;
   logic [IDLE_W-1:0]  idle_cnt;
   logic [IDLE_W-1:0]  idle_nxt;
   logic [31:0]        uptime_q;
   logic [31:0]        sp_q [NUM_SP];

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [4:0] addr;
   logic [2:0] sp_idx;
   logic       is_ro;
   logic       is_key;
   logic       is_sp;
   logic       addr_unused;

   assign addr        = OPB_ADDR[4:0];
   assign sp_idx      = addr[2:0];
   assign is_ro       = (addr <= ADDR_UPTIME);
   assign is_key      = (addr == ADDR_KEY);
   // Scratch window is 8..15; NUM_SP <= 8 keeps it inside that block.
   assign is_sp       = (addr[4:3] == 2'b01) && ({1'b0, sp_idx} < NUM_SP_W);
   assign addr_unused = ^OPB_ADDR[31:5];

   // ------------------------------------------------------------------
   // Access qualification
   // ------------------------------------------------------------------
   logic wr_key;
   logic wr_sp_ok;
   logic wr_err;
   logic rd_err;

   assign wr_key   = SP_WE && is_key;
   // Uses the lock state of this cycle, so a write that coincides with a
   // timeout relock is still accepted.
   assign wr_sp_ok = SP_WE && is_sp && (lock_state == UNLOCKED);
   // Key writes never fail; everything else that is not an accepted scratch
   // write (RO words, unmapped words, scratch while locked) is rejected.
   assign wr_err   = SP_WE && !is_key && !wr_sp_ok;
   assign rd_err   = !(is_ro || is_key || is_sp);

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   logic [31:0] rd_dat;

   always_comb begin
      rd_dat = 32'h0;
      case (addr)
         ADDR_VERSION: rd_dat = VERSION;
         ADDR_ID:      rd_dat = ID;
         ADDR_DATE:    rd_dat = DATE;
         ADDR_UPTIME:  rd_dat = uptime_q;
         ADDR_KEY:     rd_dat = {30'b0, lock_state};
         default: begin
            if (is_sp) begin
               for (int i = 0; i < NUM_SP; i++) begin
                  if (sp_idx == 3'(i)) begin
                     rd_dat = sp_q[i];
                  end
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registered response. A combined read+write returns the pre-write
   // value and reports the write's error status.
   // ------------------------------------------------------------------
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         SP_ACK <= 1'b0;
         SP_DO  <= 32'h0;
         SP_ERR <= 1'b0;
      end else begin
         SP_ACK <= SP_RE || SP_WE;
         SP_DO  <= SP_RE ? rd_dat : 32'h0;
         SP_ERR <= SP_WE ? wr_err : (SP_RE && rd_err);
      end
   end

   // ------------------------------------------------------------------
   // Uptime counter, wraps naturally
   // ------------------------------------------------------------------
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         uptime_q <= 32'h0;
      end else begin
         uptime_q <= uptime_q + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // Scratch registers with byte enables
   // ------------------------------------------------------------------
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         for (int i = 0; i < NUM_SP; i++) begin
            sp_q[i] <= SP_INIT | 32'(i);
         end
      end else if (wr_sp_ok) begin
         for (int i = 0; i < NUM_SP; i++) begin
            if (sp_idx == 3'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (SP_BE[b]) begin
                     sp_q[i][8*b +: 8] <= SP_DI[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         lock_state <= LOCKED;
         idle_cnt   <= '0;
      end else begin
         lock_state <= lock_nxt;
         idle_cnt   <= idle_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Lock FSM: next state. The idle counter is held at zero outside
   // UNLOCKED, which also clears it on entry.
   // ------------------------------------------------------------------
   always_comb begin
      lock_nxt = lock_state;
      idle_nxt = '0;
      case (lock_state)
         LOCKED: begin
            if (wr_key) begin
               lock_nxt = (SP_DI == KEY_ARM) ? ARMED : LOCKED;
            end
         end
         ARMED: begin
            if (wr_key) begin
               lock_nxt = (SP_DI == KEY_UNLOCK) ? UNLOCKED : LOCKED;
            end else if (SP_WE) begin
               // Any non-key write breaks the key sequence.
               lock_nxt = LOCKED;
            end
         end
         UNLOCKED: begin
            if (wr_key) begin
               lock_nxt = LOCKED;
            end else if ((UNLOCK_TIMEOUT != 0) && (idle_cnt == IDLE_MAX)) begin
               lock_nxt = LOCKED;
            end else if (!wr_sp_ok) begin
               idle_nxt = idle_cnt + IDLE_ONE;
            end
         end
         default: begin
            lock_nxt = LOCKED;
         end
      endcase
   end

   assign SP_LOCKED = (lock_state != UNLOCKED);

endmodule
